// File: rtl/drv_mode_arbiter.sv
// drv_mode_arbiter: registered priority selection of the stepper motion source,
// switching only at a step boundary with dead time on direction reversal.
module drv_mode_arbiter #(
    parameter int WIDTH      = 32,
    parameter int N_SRC      = 3,
    parameter int DEAD_CYC   = 16,
    parameter int MAX_WAIT   = 65535,
    parameter int MIN_PERIOD = 4,
    localparam int SW        = N_SRC > 1 ? $clog2(N_SRC) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*WIDTH-1:0] period_in,
    input  logic [N_SRC-1:0]       dir_in,
    input  logic [N_SRC-1:0]       en_in,
    input  logic [N_SRC-1:0]       cnt_en_in,
    input  logic                   step_done,
    output logic [WIDTH-1:0]       drv_period,
    output logic                   drv_dir,
    output logic                   enable,
    output logic                   counter_en,
    output logic [SW-1:0]          sel_idx,
    output logic                   sel_valid,
    output logic                   switching,
    output logic                   sw_timeout
);
    localparam int DW = DEAD_CYC > 0 ? $clog2(DEAD_CYC + 1) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [DW-1:0] DEAD_LAST = DEAD_CYC > 0 ? DW'(DEAD_CYC - 1) : '0;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DEAD} state_t;

    state_t         state, nstate;
    logic [SW-1:0]  sel, nsel, win;
    logic           found, dead_to, tmo, run, act;
    logic [WW-1:0]  wait_cnt;
    logic [DW-1:0]  dead_cnt;
    logic [WIDTH-1:0] raw;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (req[i]) begin
                win   = SW'(i);
                found = 1'b1;
            end
    end

    assign dead_to = (DEAD_CYC > 0) && (dir_in[win] != drv_dir);

    always_comb begin
        nstate = state;
        nsel   = sel;
        tmo    = 1'b0;
        case (state)
            IDLE: if (found) begin
                nsel   = win;
                nstate = dead_to ? DEAD : RUN;
            end
            RUN: if (!found || win != sel) nstate = DRAIN;
            DRAIN: if (found && win == sel) nstate = RUN;
                else if (!enable || step_done || wait_cnt == WAIT_LAST) begin
                    tmo    = enable && !step_done;
                    nsel   = found ? win : sel;
                    nstate = !found ? IDLE : dead_to ? DEAD : RUN;
                end
            // a same-direction newcomer just rides along and is taken on entry to RUN
            DEAD: if (!found) nstate = IDLE;
                else if (win != sel && dead_to) nsel = win;
                else if (dead_cnt == DEAD_LAST) begin
                    nsel   = win;
                    nstate = RUN;
                end
            default: nstate = IDLE;
        endcase
    end

    assign raw = period_in[int'(nsel) * WIDTH +: WIDTH];
    assign run = nstate == RUN || nstate == DRAIN;
    assign act = run || nstate == DEAD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            wait_cnt   <= '0;
            dead_cnt   <= '0;
            drv_period <= '0;
            drv_dir    <= 1'b0;
            enable     <= 1'b0;
            counter_en <= 1'b0;
            sel_idx    <= '0;
            sel_valid  <= 1'b0;
            switching  <= 1'b0;
            sw_timeout <= 1'b0;
        end else begin
            state      <= nstate;
            sel        <= nsel;
            wait_cnt   <= state == DRAIN && nstate == DRAIN ? wait_cnt + 1'b1 : '0;
            dead_cnt   <= state == DEAD && nstate == DEAD && nsel == sel ? dead_cnt + 1'b1 : '0;
            drv_period <= !act ? '0 : raw < WIDTH'(MIN_PERIOD) ? WIDTH'(MIN_PERIOD) : raw;
            drv_dir    <= act && dir_in[nsel];
            enable     <= run && en_in[nsel];
            counter_en <= run && cnt_en_in[nsel];
            sel_idx    <= act ? nsel : '0;
            sel_valid  <= act;
            switching  <= nstate == DRAIN || nstate == DEAD;
            sw_timeout <= tmo;
        end
    end
endmodule

// File: tb/tb_drv_mode_arbiter.sv
// tb_drv_mode_arbiter: directed stimulus with a cycle-stamped expectation queue
// drained by an independent negedge monitor.
module tb_drv_mode_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [95:0] period_in = '0;
    logic [2:0]  dir_in = '0;
    logic [2:0]  en_in = '0;
    logic [2:0]  cnt_en_in = '0;
    logic        step_done = 1'b0;
    logic [31:0] drv_period;
    logic        drv_dir, enable, counter_en, sel_valid, switching, sw_timeout;
    logic [1:0]  sel_idx;

    drv_mode_arbiter #(.WIDTH(32), .N_SRC(3), .DEAD_CYC(16), .MAX_WAIT(100), .MIN_PERIOD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .period_in(period_in), .dir_in(dir_in),
        .en_in(en_in), .cnt_en_in(cnt_en_in), .step_done(step_done),
        .drv_period(drv_period), .drv_dir(drv_dir), .enable(enable), .counter_en(counter_en),
        .sel_idx(sel_idx), .sel_valid(sel_valid), .switching(switching), .sw_timeout(sw_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [39:0] v;
    } exp_t;

    exp_t q[$];
    exp_t r;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: output vector is {period, dir, enable, counter_en, sel_idx, sel_valid, switching, sw_timeout}
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            r = q.pop_front();
            tests++;
            if (r.cyc != cyc || {drv_period, drv_dir, enable, counter_en, sel_idx, sel_valid, switching, sw_timeout} !== r.v) begin
                fails++;
                $display("FAIL %s cyc %0d (due %0d): got %h expected %h", r.name, cyc, r.cyc,
                         {drv_period, drv_dir, enable, counter_en, sel_idx, sel_valid, switching, sw_timeout}, r.v);
            end
        end
    end

    task automatic e(input int dc, input string nm, input logic [31:0] p, input logic d, input logic en,
                     input logic ce, input logic [1:0] ix, input logic v, input logic sw, input logic to);
        q.push_back('{cyc + dc, nm, {p, d, en, ce, ix, v, sw, to}});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        period_in[31:0]  = 32'd1000;
        period_in[63:32] = 32'd500;
        period_in[95:64] = 32'd3000;
        dir_in    = 3'b100;
        en_in     = 3'b111;
        cnt_en_in = 3'b111;
        tick(2);
        rst_n = 1'b1;
        e(1, "reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1);
        // idle -> run on source 0
        req = 3'b001;
        e(2, "run0", 1000, 0, 1, 1, 0, 1, 0, 0);
        tick(2);
        // source 0 keeps priority over source 1
        req = 3'b011;
        e(1, "prio0", 1000, 0, 1, 1, 0, 1, 0, 0);
        e(3, "prio0b", 1000, 0, 1, 1, 0, 1, 0, 0);
        tick(3);
        // requester returns during drain: back to run without a switch
        req = 3'b010;
        e(1, "gdrain", 1000, 0, 1, 1, 0, 1, 1, 0);
        tick(1);
        req = 3'b011;
        e(1, "gback", 1000, 0, 1, 1, 0, 1, 0, 0);
        tick(1);
        // drain held until step_done, then same-direction switch to source 1
        req = 3'b010;
        e(1, "drain", 1000, 0, 1, 1, 0, 1, 1, 0);
        tick(1);
        e(4, "drain_hold", 1000, 0, 1, 1, 0, 1, 1, 0);
        tick(4);
        step_done = 1'b1;
        e(1, "sw1", 500, 0, 1, 1, 1, 1, 0, 0);
        e(2, "run1", 500, 0, 1, 1, 1, 1, 0, 0);
        tick(1);
        step_done = 1'b0;
        tick(1);
        // reversal to source 2: 16 dead cycles
        req = 3'b100;
        e(1, "drain2", 500, 0, 1, 1, 1, 1, 1, 0);
        tick(2);
        step_done = 1'b1;
        for (int k = 1; k <= 16; k++) e(k, "dead2", 3000, 1, 0, 0, 2, 1, 1, 0);
        e(17, "run2", 3000, 1, 1, 1, 2, 1, 0, 0);
        tick(1);
        step_done = 1'b0;
        tick(16);
        // no step_done: timeout after 100 drain cycles, then reversal dead time
        req = 3'b010;
        e(1, "tdrain", 3000, 1, 1, 1, 2, 1, 1, 0);
        e(100, "tdrain_end", 3000, 1, 1, 1, 2, 1, 1, 0);
        e(101, "timeout", 500, 0, 0, 0, 1, 1, 1, 1);
        e(102, "tdead", 500, 0, 0, 0, 1, 1, 1, 0);
        e(116, "tdead_end", 500, 0, 0, 0, 1, 1, 1, 0);
        e(117, "run1b", 500, 0, 1, 1, 1, 1, 0, 0);
        tick(117);
        // period clamp to MIN_PERIOD
        period_in[31:0] = 32'd2;
        req = 3'b001;
        e(1, "cdrain", 500, 0, 1, 1, 1, 1, 1, 0);
        tick(1);
        step_done = 1'b1;
        e(1, "clamp", 4, 0, 1, 1, 0, 1, 0, 0);
        tick(1);
        step_done = 1'b0;
        // all requests dropped: drain, then idle at the boundary
        req = 3'b000;
        e(1, "ldrain", 4, 0, 1, 1, 0, 1, 1, 0);
        tick(1);
        step_done = 1'b1;
        e(1, "idle", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1);
        step_done = 1'b0;
        // reset asserted mid-dead time, off the clock edge
        req = 3'b100;
        e(1, "idead", 3000, 1, 0, 0, 2, 1, 1, 0);
        tick(3);
        #3;
        rst_n = 1'b0;
        e(0, "rst_async", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        e(0, "rst_hold", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        e(1, "re_dead", 3000, 1, 0, 0, 2, 1, 1, 0);
        e(17, "re_run", 3000, 1, 1, 1, 2, 1, 0, 0);
        tick(17);
        tick(2);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL unchecked: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/drv_mode_arbiter.md
Name: drv_mode_arbiter

Overview:
- Registered successor to the combinational stepper-drive mode multiplexer.
- Selects one of N_SRC motion sources (tracking, transfer, positioning, …) for the single stepper driver.
- Source changes are made only at a step boundary, with a programmable dead time on direction reversal.
- Sits between the per-mode trajectory generators and the step-pulse driver. All outputs are registered and hold a defined value in every state.

Parameters:
- WIDTH, 32: period word width in bits.
- N_SRC, 3: number of motion sources; index 0 has the highest priority.
- DEAD_CYC, 16: driver-disabled clk cycles inserted when the new source's direction differs from the current drv_dir. 0 = no dead time.
- MAX_WAIT, 65535: clk cycles to wait in DRAIN for step_done before forcing the switch.
- MIN_PERIOD, 4: lower clamp applied to drv_period.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_SRC  per-source request level
- period_in  in  N_SRC*WIDTH  packed periods; source i occupies [i*WIDTH +: WIDTH]
- dir_in  in  N_SRC  per-source direction
- en_in  in  N_SRC  per-source driver enable
- cnt_en_in  in  N_SRC  per-source position-counter enable
- step_done  in  1  one-cycle pulse from the driver at the end of each step period
- drv_period  out  WIDTH  period to driver
- drv_dir  out  1  direction to driver
- enable  out  1  driver enable
- counter_en  out  1  position-counter enable
- sel_idx  out  $clog2(N_SRC) (min 1)  active source index
- sel_valid  out  1  a source is active
- switching  out  1  high in DRAIN or DEAD
- sw_timeout  out  1  one-cycle pulse when a DRAIN ends by timeout

Behaviour:
- Reset (async assert, sync release): state = IDLE; all outputs and counters = 0.
- win = lowest index i with req[i]=1. No request = none.
- IDLE:
  - Outputs are zero.
  - If a winner exists: sel <= win; go to DEAD if DEAD_CYC>0 and dir_in[win] != drv_dir, else go to RUN.
  - Out of reset drv_dir=0, so a winner with dir 1 gets dead time.
- RUN, outputs for sel:
  - drv_period = max(period_in[sel], MIN_PERIOD), unsigned compare.
  - drv_dir = dir_in[sel]; enable = en_in[sel]; counter_en = cnt_en_in[sel]; sel_valid = 1.
  - Outputs are registered, so latency is 1 clk from an input change to the output.
  - If win != sel, or no request: go to DRAIN, capture the pending target (win or none), clear the wait counter.
- DRAIN:
  - Outputs stay at the old sel's values.
  - The pending target is re-evaluated every cycle. If the requester returns to sel, go back to RUN with no glitch.
  - Exit condition, checked in this order:
    - enable == 0 already: exit immediately next cycle.
    - step_done == 1: exit.
    - Wait counter reaches MAX_WAIT-1: exit and pulse sw_timeout.
  - Exit target:
    - Pending none: IDLE.
    - Pending direction differs from drv_dir and DEAD_CYC > 0: DEAD.
    - Otherwise: RUN with sel <= pending.
- DEAD:
  - enable = 0, counter_en = 0.
  - drv_dir = the new source's direction (presented during dead time); drv_period = the new source's clamped period.
  - sel is already updated.
  - Counts DEAD_CYC cycles, then goes to RUN.
  - A higher-priority request arriving during DEAD retargets sel and restarts the count only if its direction differs from drv_dir; otherwise it is taken on entry to RUN.
  - All requests dropping during DEAD: go to IDLE.
- step_done coincident with the request change in RUN: the change takes effect on the next boundary. DRAIN is entered this cycle; an early exit requires enable == 0.
- Widths:
  - Wait counter is $clog2(MAX_WAIT+1) bits; dead counter is $clog2(DEAD_CYC+1) bits (min 1). Neither wraps; both saturate/clear on state exit.
- Reset assertion mid-operation drops all outputs to 0 asynchronously.

Test Plan:
- Reset, then req=3'b001, dir_in=0, period_in[0]=1000, en_in=1 → IDLE→RUN. Cycle 2 after req: drv_period=1000, enable=1, sel_idx=0, switching=0.
- In RUN on src0 (dir 0), raise req=3'b011 → src0 keeps priority, no switch. Then req=3'b010, dir_in[1]=0 → DRAIN held until the step_done pulse. Next cycle: sel_idx=1, drv_period=period_in[1], no dead time.
- Switch to src2 with dir_in[2]=1, DEAD_CYC=16 → after step_done: enable=0 for exactly 16 cycles, drv_dir=1 throughout; then enable=en_in[2].
- MAX_WAIT=100, switch request, step_done never pulses → DRAIN for 100 cycles, one-cycle sw_timeout pulse, then switch.
- period_in[0]=2, MIN_PERIOD=4 → drv_period=4. Drop all req in RUN → after step_done: IDLE, all outputs 0.
- Assert rst_n low mid-DEAD, off a clock edge → all outputs 0 immediately. After release with req held → re-enter via IDLE.
